uart_tx_fifo_from_glitcher: RTL and testbench

- Return-path counterpart to the UART RX collector that feeds the glitcher.
- Accepts result/status bytes from the glitcher side and buffers them in a small FIFO.
- Once a full packet (or a flushed partial packet) is buffered, drains it to the UART transmitter one byte at a time, waiting for the transmitter's done pulse between bytes.

---
 rtl/uart_tx_fifo_from_glitcher.sv | 125 ++++++++++++
 tb/tb_uart_tx_fifo_from_glitcher.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_from_glitcher.sv
// Return-path buffer: collects result bytes from the glitcher and drains them
// to the UART transmitter in packets, one byte per tx_done handshake.
module uart_tx_fifo_from_glitcher #(
    parameter int DEPTH   = 8,
    parameter int PKT_LEN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_dv,
    input  logic [7:0]                 in_byte,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       tx_dv,
    output logic [7:0]                 tx_byte,
    input  logic                       tx_done,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_DONE
    } state_t;

    state_t          state;
    logic [7:0]      fifo [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   burst_left;
    logic            flush_pend;
    logic            push;
    logic            pop;

    assign in_ready = (count < CW'(DEPTH));
    assign push     = in_dv && in_ready;
    assign pop      = (state == LOAD);

    // Storage needs no reset; stale entries are never read before being rewritten.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= in_byte;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (in_dv && !in_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    // In IDLE every path consumes a pending flush, so only a fresh pulse survives;
    // during a burst pulses accumulate until the FSM returns to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            burst_left <= '0;
            flush_pend <= 1'b0;
            tx_dv      <= 1'b0;
            tx_byte    <= 8'h00;
            busy       <= 1'b0;
        end else begin
            tx_dv <= 1'b0;
            case (state)
                IDLE: begin
                    flush_pend <= flush;
                    if (count >= CW'(PKT_LEN)) begin
                        burst_left <= CW'(PKT_LEN);
                        state      <= LOAD;
                        busy       <= 1'b1;
                    end else if (flush_pend && (count != '0)) begin
                        burst_left <= count;
                        state      <= LOAD;
                        busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    flush_pend <= flush_pend | flush;
                    tx_byte    <= fifo[rd_ptr];
                    tx_dv      <= 1'b1;
                    burst_left <= burst_left - CW'(1);
                    state      <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    flush_pend <= flush_pend | flush;
                    if (tx_done) begin
                        if (burst_left == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_from_glitcher.sv
// Self-checking bench: a queue model of the byte stream checks every strobe,
// occupancy and overflow, while directed sequences cover latency and corner cases.
module tb_uart_tx_fifo_from_glitcher;

    localparam int DEPTH    = 8;
    localparam int PKT_LEN  = 4;
    localparam int TX_DELAY = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_dv = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       in_ready;
    logic       flush = 1'b0;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_done;
    logic       busy;
    logic [3:0] count;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    uart_tx_fifo_from_glitcher #(.DEPTH(DEPTH), .PKT_LEN(PKT_LEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_dv    (in_dv),
        .in_byte  (in_byte),
        .in_ready (in_ready),
        .flush    (flush),
        .tx_dv    (tx_dv),
        .tx_byte  (tx_byte),
        .tx_done  (tx_done),
        .busy     (busy),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // UART TX stand-in: answers each strobe with tx_done TX_DELAY cycles later
    logic resp_done = 1'b0;
    logic extra_done = 1'b0;
    logic hold_done = 1'b0;
    int   timer = 0;
    bit   pend = 0;
    assign tx_done = resp_done | extra_done;

    always @(posedge clk) begin
        #1;
        resp_done = 1'b0;
        if (!rst) begin
            pend  = 0;
            timer = 0;
        end else if (tx_dv) begin
            pend  = 1;
            timer = TX_DELAY;
        end else if (pend && !hold_done) begin
            if (timer <= 1) begin
                resp_done = 1'b1;
                pend      = 0;
            end else begin
                timer--;
            end
        end
    end

    // Reference model: accepted bytes wait in a queue and must leave in order
    logic [7:0] exp_q[$];
    int  strobes = 0;
    bit  exp_ovf = 0;
    bit  prev_dv = 0;

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            strobes = 0;
            exp_ovf = 0;
            prev_dv = 0;
        end else begin
            if (tx_dv) begin
                checkOutput("tx_dv_single_cycle", int'(prev_dv), 0);
                if (exp_q.size() == 0) begin
                    checkOutput("tx_unexpected_strobe", 1, 0);
                end else begin
                    checkOutput("tx_byte_order", int'(tx_byte), int'(exp_q.pop_front()));
                end
                strobes++;
            end
            prev_dv = tx_dv;
            checkOutput("count_model", int'(count), exp_q.size());
            checkOutput("in_ready_model", int'(in_ready), int'(exp_q.size() < DEPTH));
            checkOutput("overflow_model", int'(overflow), int'(exp_ovf));
            if (in_dv) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(in_byte);
                else exp_ovf = 1;
            end
        end
    end

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       fl;
        int         exp_count;
        logic       exp_busy;
        logic       exp_dv;
    } vec_t;

    vec_t vecs[6];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        in_dv   = 1'b1;
        in_byte = b;
        @(posedge clk);
        #1;
        in_dv   = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        in_dv   = v.wr;
        in_byte = v.data;
        flush   = v.fl;
        @(posedge clk);
        #1;
        in_dv   = 1'b0;
        flush   = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("vec%0d_count", idx), int'(count), v.exp_count);
        checkOutput($sformatf("vec%0d_busy", idx), int'(busy), int'(v.exp_busy));
        checkOutput($sformatf("vec%0d_tx_dv", idx), int'(tx_dv), int'(v.exp_dv));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int i = 0; i < 3000 && quiet < 3; i++) begin
            @(negedge clk);
            quiet = busy ? 0 : quiet + 1;
        end
        checkOutput("wait_idle_timeout", int'(quiet >= 3), 1);
        @(posedge clk);
        #1;
    endtask

    // Returns 2 time units into a cycle in which the FSM is in LOAD
    task automatic wait_load();
        bit found = 0;
        logic pb, pd;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            pb = busy;
            pd = tx_done;
            @(posedge clk);
            #2;
            if (busy && (!pb || pd)) found = 1;
        end
        checkOutput("wait_load_timeout", int'(found), 1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int s0, k, c0, bad, n;
        vecs[0] = '{1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h22, 1'b0, 2, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h33, 1'b0, 3, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 3, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 2, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 2, 1'b1, 1'b0};

        tick(3);
        @(negedge clk);
        checkOutput("reset_tx_dv", int'(tx_dv), 0);
        checkOutput("reset_tx_byte", int'(tx_byte), 0);
        checkOutput("reset_count", int'(count), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_overflow", int'(overflow), 0);
        checkOutput("reset_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(2);

        $display("[TB] full packet and latency");
        s0 = strobes;
        write_byte(8'hA1);
        write_byte(8'hA2);
        write_byte(8'hA3);
        write_byte(8'hA4);
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            @(negedge clk);
            if (tx_dv) k = i;
        end
        checkOutput("first_tx_latency", k, 3);
        k = 0;
        for (int i = 0; i < 50 && !tx_done; i++) @(negedge clk);
        for (int i = 1; i <= 20 && k == 0; i++) begin
            @(negedge clk);
            if (tx_dv) k = i;
        end
        checkOutput("done_to_tx_latency", k, 2);
        bad = 0;
        n = 0;
        while ((strobes - s0) < 4 && n < 300) begin
            @(negedge clk);
            n++;
            if (!busy) bad++;
        end
        checkOutput("busy_during_burst", bad, 0);
        wait_idle();
        checkOutput("pkt_strobes", strobes - s0, 4);
        checkOutput("pkt_end_count", int'(count), 0);

        $display("[TB] partial packet and flush");
        s0 = strobes;
        for (int i = 0; i < 3; i++) applyStimulus(vecs[i], i);
        tick(100);
        checkOutput("no_tx_without_flush", strobes - s0, 0);
        checkOutput("held_count", int'(count), 3);
        for (int i = 3; i < 6; i++) applyStimulus(vecs[i], i);
        wait_idle();
        checkOutput("flush_strobes", strobes - s0, 3);
        checkOutput("flush_burst_left", int'(dut.burst_left), 0);
        checkOutput("flush_end_count", int'(count), 0);

        $display("[TB] coincident push/pop with wrap");
        s0 = strobes;
        for (int i = 0; i < 4; i++) write_byte(8'hB0 + 8'(i));
        for (int i = 0; i < 4; i++) begin
            wait_load();
            c0 = int'(count);
            in_dv   = 1'b1;
            in_byte = 8'(($urandom_range(0, 255) & 8'hF0) | 8'h0C) ^ 8'(i);
            @(posedge clk);
            #1;
            in_dv = 1'b0;
            @(negedge clk);
            checkOutput($sformatf("push_pop_count%0d", i), int'(count), c0);
        end
        wait_idle();
        checkOutput("wrap_strobes", strobes - s0, 8);
        checkOutput("wrap_end_count", int'(count), 0);

        $display("[TB] tx_done in IDLE and LOAD");
        s0 = strobes;
        extra_done = 1'b1;
        tick(1);
        extra_done = 1'b0;
        tick(5);
        checkOutput("idle_done_busy", int'(busy), 0);
        checkOutput("idle_done_strobes", strobes - s0, 0);
        for (int i = 0; i < 4; i++) write_byte(8'($urandom_range(0, 255)));
        wait_load();
        extra_done = 1'b1;
        @(posedge clk);
        #1;
        extra_done = 1'b0;
        tick(3);
        checkOutput("load_done_strobes", strobes - s0, 1);
        wait_idle();
        checkOutput("load_done_total", strobes - s0, 4);

        $display("[TB] overflow with tx_done held");
        s0 = strobes;
        hold_done = 1'b1;
        for (int i = 0; i < 10; i++) write_byte(8'h40 + 8'(i));
        @(negedge clk);
        checkOutput("ovf_flag", int'(overflow), 1);
        checkOutput("ovf_count", int'(count), DEPTH);
        checkOutput("ovf_in_ready", int'(in_ready), 0);
        checkOutput("ovf_strobes_held", strobes - s0, 1);
        @(posedge clk);
        #1;
        hold_done = 1'b0;
        wait_idle();
        checkOutput("ovf_drain_strobes", strobes - s0, 8);
        checkOutput("ovf_left_count", int'(count), 1);
        checkOutput("ovf_sticky", int'(overflow), 1);

        $display("[TB] reset mid-burst");
        s0 = strobes;
        for (int i = 0; i < 4; i++) write_byte(8'hE0 + 8'(i));
        n = 0;
        while ((strobes - s0) < 2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("midburst_reached", int'((strobes - s0) >= 2), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("abort_tx_dv", int'(tx_dv), 0);
        checkOutput("abort_count", int'(count), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_overflow", int'(overflow), 0);
        tick(2);
        rst = 1'b1;
        tick(2);
        s0 = strobes;
        for (int i = 0; i < 4; i++) write_byte(8'hF0 + 8'(i));
        wait_idle();
        checkOutput("post_reset_strobes", strobes - s0, 4);
        checkOutput("post_reset_count", int'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
